// File: rtl/pdm_pkg.sv
// Shared constants and width helpers for the PDM transmit and CIC receive paths.
package pdm_pkg;

  localparam int MIN_RATE = 2;

  function automatic int acc_width(input int in_w, input int n, input int rate_w);
    return in_w + (n - 1) * rate_w;
  endfunction

  // Modulator feedback level: +/- 2^(in_w-1).
  function automatic int full_scale(input int in_w);
    return 1 << (in_w - 1);
  endfunction

endpackage

// File: rtl/sigma_delta_mod.sv
// First-order sigma-delta modulator: one PDM bit per clock from a signed level y.
module sigma_delta_mod
  import pdm_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] y,
  output logic                   dout
);

  localparam int S_W = IN_W + 2;
  localparam logic signed [S_W-1:0] FS = S_W'(full_scale(IN_W));

  logic signed [S_W-1:0] s;
  logic signed [S_W-1:0] v;
  logic signed [S_W-1:0] y_ext;
  logic signed [S_W-1:0] s_next;

  always_comb begin
    v      = dout ? FS : -FS;
    y_ext  = {{2{y[IN_W-1]}}, y};
    s_next = s + y_ext - v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      dout <= 1'b0;
    end else begin
      s    <= s_next;
      dout <= ~s_next[S_W-1];
    end
  end

endmodule

// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: slot counter, N-stage CIC interpolator, gain scaler
// and a first-order sigma-delta modulator.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int N      = 3,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] int_num,
  input  logic [4:0]        shift,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              underrun
);

  localparam int ACC_W = acc_width(IN_W, N, RATE_W);
  localparam logic [RATE_W-1:0]       RATE_MIN = RATE_W'(MIN_RATE);
  localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'(full_scale(IN_W) - 1);

  logic [RATE_W-1:0] phase;
  logic [RATE_W-1:0] rate_eff;
  logic              slot;
  logic              slot_q;

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] comb_c [N+1];
  logic signed [ACC_W-1:0] comb_d [N];
  logic signed [ACC_W-1:0] comb_q;
  logic signed [ACC_W-1:0] integ  [N];
  logic signed [ACC_W-1:0] integ_in;
  logic signed [ACC_W-1:0] scaled;
  logic signed [ACC_W-1:0] clamped;
  logic signed [IN_W-1:0]  y_q;

  always_comb begin
    slot     = (phase == '0);
    in_ready = slot;
    rate_eff = (int_num < RATE_MIN) ? RATE_MIN : int_num;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= '0;
      slot_q   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      phase  <= slot ? (rate_eff - RATE_W'(1)) : (phase - RATE_W'(1));
      slot_q <= slot;
      if (slot && !in_valid) underrun <= 1'b1;
    end
  end

  // Comb chain: c_k = x minus the sum of all earlier stage delays.
  always_comb begin
    logic signed [ACC_W-1:0] acc;
    x         = in_valid ? {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data} : '0;
    acc       = x;
    comb_c[0] = x;
    for (int k = 0; k < N; k++) begin
      acc         = acc - comb_d[k];
      comb_c[k+1] = acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) comb_d[k] <= '0;
      comb_q <= '0;
    end else if (slot) begin
      for (int k = 0; k < N; k++) comb_d[k] <= comb_c[k];
      comb_q <= comb_c[N];
    end
  end

  // Zero-stuffing: the comb result enters the integrators for one cycle only.
  assign integ_in = slot_q ? comb_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else begin
      integ[0] <= integ[0] + integ_in;
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_comb begin
    scaled = integ[N-1] >>> shift;
    if (scaled > Y_MAX)       clamped = Y_MAX;
    else if (scaled < -Y_MAX) clamped = -Y_MAX;
    else                      clamped = scaled;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= clamped[IN_W-1:0];
  end

  sigma_delta_mod #(.IN_W(IN_W)) u_mod (
    .clk  (clk),
    .rst  (rst),
    .y    (y_q),
    .dout (dout)
  );

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx: closed-form CIC reference with random stimulus,
// plus slot timing, underrun and PDM duty checks.
module tb_pdm_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] int_num;
  logic [4:0] shift;
  logic [15:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       dout;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  pdm_tx dut (
    .clk      (clk),
    .rst      (rst),
    .int_num  (int_num),
    .shift    (shift),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_dout", dout, 0);
      check("rst_underrun", underrun, 0);
    end
    rst = 1'b0;
  endtask

  // Reference: accepted samples go through an N=3 binomial difference, land as
  // impulses two states after their slot, and the triple running sum is the
  // convolution with C(t-j,2). Then shift/saturate and the modulator rule.
  task automatic run_exact(input int r, input int sh, input int ncyc, input int mode);
    int     reff;
    int     next_slot;
    int     slot_n;
    bit     slot;
    longint xp0, xp1, xp2, xv, c, i3, ys, sn, v;
    longint uj[$];
    longint uc[$];
    logic signed [31:0] w;
    longint m_y, m_s;
    bit     m_dout, m_under;
    do_reset();
    int_num = 8'(r);
    shift   = 5'(sh);
    reff = (r < 2) ? 2 : r;
    next_slot = 0; slot_n = 0;
    xp0 = 0; xp1 = 0; xp2 = 0;
    m_y = 0; m_s = 0; m_dout = 0; m_under = 0;
    for (int k = 0; k < ncyc; k++) begin
      slot = (k == next_slot);
      check("dout", dout, m_dout);
      check("in_ready", in_ready, slot);
      check("underrun", underrun, m_under);
      if (mode == 0) begin
        in_valid = ($urandom_range(9) != 0);
        in_data  = 16'($urandom);
      end else begin
        in_valid = !(slot && slot_n == 2);
        in_data  = 16'd8000;
      end
      if (slot) begin
        xv = in_valid ? longint'($signed(in_data)) : 0;
        if (!in_valid) m_under = 1;
        c = xv - 3 * xp0 + 3 * xp1 - xp2;
        xp2 = xp1; xp1 = xp0; xp0 = xv;
        uj.push_back(k + 2);
        uc.push_back(c);
        next_slot = k + reff;
        slot_n++;
      end
      i3 = 0;
      for (int e = 0; e < uj.size(); e++)
        if (uj[e] <= k) i3 += ((k - uj[e]) * (k - uj[e] - 1) / 2) * uc[e];
      w  = i3[31:0];
      ys = longint'(w >>> sh);
      if (ys > 32767) ys = 32767;
      if (ys < -32767) ys = -32767;
      v  = m_dout ? 32768 : -32768;
      sn = m_s + m_y - v;
      m_s = sn;
      m_dout = (sn >= 0);
      m_y = ys;
      tick();
    end
  endtask

  task automatic ones_test(input string tag, input int r, input int sh, input int data,
                           input int lo, input int hi);
    int cnt;
    do_reset();
    int_num  = 8'(r);
    shift    = 5'(sh);
    in_valid = 1'b1;
    in_data  = 16'(data);
    for (int i = 0; i < 64; i++) tick();
    cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      cnt += int'(dout);
      tick();
    end
    check(tag, (cnt >= lo && cnt <= hi) ? lo : cnt, lo);
  endtask

  task automatic rate_change_test();
    int  next_slot;
    bit  rdy [64];
    do_reset();
    shift = 5'd4; in_valid = 1'b1; in_data = '0;
    int_num = 8'd4;
    next_slot = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 2)  int_num = 8'd8;
      if (k == 30) int_num = 8'd0;
      if (k == 44) int_num = 8'd1;
      rdy[k] = in_ready;
      check("rc_ready", in_ready, (k == next_slot));
      if (k == next_slot) next_slot = k + ((int_num < 2) ? 2 : int'(int_num));
      tick();
    end
    check("rc_slot4", rdy[4], 1);
    check("rc_gap8", rdy[8], 0);
    check("rc_slot12", rdy[12], 1);
    check("rc_slot20", rdy[20], 1);
  endtask

  initial begin
    int_num = 8'd4; shift = 5'd4;

    // Reset and 4-cycle slot cadence.
    do_reset();
    int_num = 8'd4; in_valid = 1'b1; in_data = '0;
    for (int k = 0; k < 12; k++) begin
      check("cadence_ready", in_ready, (k % 4 == 0));
      tick();
    end

    // Underrun on one dropped slot, then sticky until reset.
    run_exact(4, 4, 40, 1);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("underrun_sticky", underrun, 1);
      tick();
    end
    do_reset();
    check("underrun_cleared", underrun, 0);

    for (int s = 0; s < 5; s++)
      run_exact($urandom_range(0, 20), $urandom_range(0, 10), 500, 0);
    run_exact(1, 2, 200, 0);

    rate_change_test();

    ones_test("ones_zero", 4, 4, 0, 2028, 2068);
    ones_test("ones_half", 4, 4, 16384, 3052, 3092);
    ones_test("ones_sat", 16, 0, 32767, 4090, 4096);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
